// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control tokens, receive states and symbol decode helpers
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] ctrl;
  } ctrl_match_t;

  // Undo the optional inversion (bit 9) and then the XOR/XNOR chain (bit 8).
  function automatic logic [7:0] tmds_decode_8b(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] q;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  function automatic ctrl_match_t tmds_ctrl_match(input logic [9:0] sym);
    ctrl_match_t m;
    m.valid = 1'b1;
    m.ctrl  = 2'b00;
    case (sym)
      CTRL_TOKEN_00: m.ctrl = 2'b00;
      CTRL_TOKEN_01: m.ctrl = 2'b01;
      CTRL_TOKEN_10: m.ctrl = 2'b10;
      CTRL_TOKEN_11: m.ctrl = 2'b11;
      default:       m.valid = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tmds_bit_aligner.sv
// rtl/tmds_bit_aligner.sv - two-word history window and registered 10-bit offset selector
module tmds_bit_aligner (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_data,
  input  logic [3:0] slip_offset,
  output logic [9:0] aligned
);

  logic [9:0]  prev;
  logic [19:0] window;
  logic [9:0]  sel;

  assign window = {raw_data, prev};

  // Constant slices only; offsets above 9 never occur and select zero.
  always_comb begin
    sel = '0;
    for (int k = 0; k < 10; k++) begin
      if (slip_offset == 4'(k)) begin
        sel = window[k +: 10];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= '0;
      aligned <= '0;
    end else begin
      prev    <= raw_data;
      aligned <= sel;
    end
  end

endmodule

// File: rtl/tmds_rx_aligner.sv
// rtl/tmds_rx_aligner.sv - per-channel TMDS symbol alignment search, lock tracking and decode
module tmds_rx_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS = 16,
  parameter int WINDOW      = 2048,
  parameter int MAX_GAP     = 4096
) (
  input  logic       pix_clk,
  input  logic       reset,
  input  logic [9:0] raw_data,
  output logic [7:0] pix_data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] slip_offset
);

  localparam int TOK_W = $clog2(LOCK_TOKENS + 1);
  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  rx_state_t   state, state_nx;
  logic [TOK_W-1:0] tok_cnt, tok_cnt_nx;
  logic [WIN_W-1:0] win_cnt, win_cnt_nx;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
  logic [3:0]  offset_nx;
  logic [9:0]  aligned;
  ctrl_match_t match;
  logic [7:0]  pix_data_nx;
  logic [1:0]  ctrl_nx;
  logic        de_nx;

  tmds_bit_aligner u_bit_aligner (
    .clk         (pix_clk),
    .reset       (reset),
    .raw_data    (raw_data),
    .slip_offset (slip_offset),
    .aligned     (aligned)
  );

  assign match  = tmds_ctrl_match(aligned);
  assign locked = (state == LOCKED);

  always_comb begin
    state_nx   = state;
    tok_cnt_nx = tok_cnt;
    win_cnt_nx = win_cnt;
    gap_cnt_nx = gap_cnt;
    offset_nx  = slip_offset;
    if (state == SEARCH) begin
      tok_cnt_nx = match.valid ? tok_cnt + 1'b1 : '0;
      win_cnt_nx = win_cnt + 1'b1;
      // Lock takes priority over a window expiry landing on the same word.
      if (match.valid && tok_cnt == TOK_W'(LOCK_TOKENS - 1)) begin
        state_nx   = LOCKED;
        tok_cnt_nx = '0;
        win_cnt_nx = '0;
        gap_cnt_nx = '0;
      end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
        offset_nx  = (slip_offset == 4'd9) ? 4'd0 : slip_offset + 4'd1;
        tok_cnt_nx = '0;
        win_cnt_nx = '0;
      end
    end else begin
      gap_cnt_nx = match.valid ? '0 : gap_cnt + 1'b1;
      if (!match.valid && gap_cnt == GAP_W'(MAX_GAP - 1)) begin
        state_nx   = SEARCH;
        tok_cnt_nx = '0;
        win_cnt_nx = '0;
        gap_cnt_nx = '0;
      end
    end
  end

  // Decode follows the next state so outputs never disagree with locked.
  always_comb begin
    pix_data_nx = '0;
    ctrl_nx     = '0;
    de_nx       = 1'b0;
    if (state_nx == LOCKED) begin
      ctrl_nx = ctrl;
      if (match.valid) begin
        ctrl_nx = match.ctrl;
      end else begin
        de_nx       = 1'b1;
        pix_data_nx = tmds_decode_8b(aligned);
      end
    end
  end

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      state       <= SEARCH;
      tok_cnt     <= '0;
      win_cnt     <= '0;
      gap_cnt     <= '0;
      slip_offset <= '0;
      pix_data    <= '0;
      ctrl        <= '0;
      de          <= 1'b0;
    end else begin
      state       <= state_nx;
      tok_cnt     <= tok_cnt_nx;
      win_cnt     <= win_cnt_nx;
      gap_cnt     <= gap_cnt_nx;
      slip_offset <= offset_nx;
      pix_data    <= pix_data_nx;
      ctrl        <= ctrl_nx;
      de          <= de_nx;
    end
  end

endmodule
